conv1d_obi_fetch: RTL and testbench

OBI initiator that streams conv1d input samples from system memory.
- On `start_i` it issues `len_i` word reads from `base_addr_i` on the OBI bus.
- Read data is buffered in a small FIFO and presented on a valid/ready stream to the conv1d datapath.
- Sits alongside the conv1d wrapper. Base address and length come from the control registers; `done_o` feeds the completion logic.

---
 rtl/conv1d_obi_fetch.sv | 243 ++++++++++++++++++++++++
 tb/tb_conv1d_obi_fetch.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1d_obi_fetch.sv
// rtl/conv1d_obi_fetch.sv - OBI read initiator streaming conv1d input samples
//
// Purpose: on start_i, fetches len_i consecutive words from base_addr_i over
// OBI, buffers the read data in a small FIFO and presents it on a
// valid/ready stream. done_o pulses when the last word leaves the stream.
//
// Optional build macro: CONV1D_FETCH_ERR_EN adds obi_err_i / err_o.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   start_i                  start pulse, sampled in IDLE only
//   base_addr_i, len_i       first word address (low bits ignored), word count
//   busy_o, done_o           transfer in progress, completion pulse
//   obi_req_o .. obi_wdata_o OBI request channel (reads only)
//   obi_gnt_i                OBI grant
//   obi_rvalid_i, obi_rdata_i OBI response channel
//   obi_err_i, err_o         response error in, sticky error out (macro only)
//   data_o, valid_o, ready_i output sample stream

module conv1d_obi_fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A push into a full FIFO is accepted when a pop frees the head slot
    // in the same cycle.
    assign do_pop  = pop_i && (count_o != '0);
    assign do_push = push_i && ((count_o != CW'(DEPTH)) || do_pop);
    assign rdata_o = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            if (do_push && !do_pop)      count_o <= count_o + CW'(1);
            else if (do_pop && !do_push) count_o <= count_o - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= wdata_i;
    end
endmodule

module conv1d_obi_fetch #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int MAX_OUTST  = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic [ADDR_WIDTH-1:0]     base_addr_i,
    input  logic [LEN_WIDTH-1:0]      len_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      obi_req_o,
    input  logic                      obi_gnt_i,
    output logic [ADDR_WIDTH-1:0]     obi_addr_o,
    output logic                      obi_we_o,
    output logic [DATA_WIDTH/8-1:0]   obi_be_o,
    output logic [DATA_WIDTH-1:0]     obi_wdata_o,
    input  logic                      obi_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     obi_rdata_i,
`ifdef CONV1D_FETCH_ERR_EN
    input  logic                      obi_err_i,
    output logic                      err_o,
`endif
    output logic [DATA_WIDTH-1:0]     data_o,
    output logic                      valid_o,
    input  logic                      ready_i
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OW    = $clog2(MAX_OUTST + 1);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state;
    logic                  req_q;
    logic                  done_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  req_cnt;
    logic [LEN_WIDTH-1:0]  rsp_cnt;
    logic [LEN_WIDTH-1:0]  req_cnt_n;
    logic [LEN_WIDTH-1:0]  rsp_cnt_n;
    logic [OW-1:0]         outst;
    logic [OW-1:0]         outst_n;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         fifo_count_n;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  grant;
    logic                  rsp_ok;
    logic                  pop;
    logic                  credit_n;
`ifdef CONV1D_FETCH_ERR_EN
    logic                  err_q;
`endif

    assign grant   = req_q & obi_gnt_i;
    // A response with nothing outstanding is dropped rather than corrupting
    // the counters.
    assign rsp_ok  = obi_rvalid_i & (outst != '0);
    assign valid_o = (fifo_count != '0);
    assign pop     = valid_o & ready_i;

    // Next-cycle counter values; the request for the next cycle is decided
    // from these so a zero-wait memory keeps one word per cycle flowing.
    // Outstanding reads plus buffered words never exceed the FIFO depth, so
    // every response has a slot waiting for it.
    always_comb begin
        req_cnt_n    = req_cnt - LEN_WIDTH'(grant);
        rsp_cnt_n    = rsp_cnt - LEN_WIDTH'(rsp_ok);
        outst_n      = outst + OW'(grant) - OW'(rsp_ok);
        fifo_count_n = fifo_count + CW'(rsp_ok) - CW'(pop);
        credit_n     = (int'(outst_n) < MAX_OUTST) &&
                       ((int'(outst_n) + int'(fifo_count_n)) < FIFO_DEPTH);
    end

    conv1d_obi_fetch_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (rsp_ok),
        .wdata_i (obi_rdata_i),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            req_cnt <= '0;
            rsp_cnt <= '0;
            outst   <= '0;
`ifdef CONV1D_FETCH_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            done_q  <= 1'b0;
            req_cnt <= req_cnt_n;
            rsp_cnt <= rsp_cnt_n;
            outst   <= outst_n;
            if (grant) addr_q <= addr_q + ADDR_WIDTH'(BYTES);
`ifdef CONV1D_FETCH_ERR_EN
            if (rsp_ok && obi_err_i) err_q <= 1'b1;
`endif
            case (state)
                IDLE: begin
                    req_q <= 1'b0;
                    if (start_i) begin
`ifdef CONV1D_FETCH_ERR_EN
                        err_q <= 1'b0;
`endif
                        if (len_i != '0) begin
                            state   <= FETCH;
                            addr_q  <= base_addr_i & ~ADDR_WIDTH'(BYTES - 1);
                            req_cnt <= len_i;
                            rsp_cnt <= len_i;
                            req_q   <= 1'b1;
                        end else begin
                            done_q  <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    // An ungranted request holds; otherwise re-arm on credit.
                    req_q <= (req_q && !obi_gnt_i) ||
                             ((req_cnt_n != '0) && credit_n);
                    if (req_cnt_n == '0) state <= DRAIN;
                end
                DRAIN: begin
                    req_q <= 1'b0;
                    if ((rsp_cnt_n == '0) && (fifo_count_n == '0)) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(obi_rvalid_i && (outst == '0)))
                else $error("obi rvalid with no read outstanding");
        end
    end
`endif

    assign busy_o      = (state != IDLE);
    assign done_o      = done_q;
    assign obi_req_o   = req_q;
    assign obi_addr_o  = addr_q;
    assign obi_we_o    = 1'b0;
    assign obi_be_o    = '1;
    assign obi_wdata_o = '0;
    assign data_o      = valid_o ? fifo_head : '0;
`ifdef CONV1D_FETCH_ERR_EN
    assign err_o       = err_q;
`endif
endmodule

// File: tb/tb_conv1d_obi_fetch.sv
// tb/tb_conv1d_obi_fetch.sv - directed self-checking bench for conv1d_obi_fetch

module tb_conv1d_obi_fetch;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] base_addr_i = '0;
    logic [15:0] len_i = '0;
    logic        busy_o;
    logic        done_o;
    logic        obi_req_o;
    logic        obi_gnt_i;
    logic [31:0] obi_addr_o;
    logic        obi_we_o;
    logic [3:0]  obi_be_o;
    logic [31:0] obi_wdata_o;
    logic        obi_rvalid_i = 1'b0;
    logic [31:0] obi_rdata_i = '0;
    logic [31:0] data_o;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic        gnt_en = 1'b1;
`ifdef CONV1D_FETCH_ERR_EN
    logic        obi_err_i = 1'b0;
    logic        err_o;
    logic        err_prev = 1'b0;
    int          err_abs = -1;
    int          rerr_cyc = -1;
    int          err_rise_cyc = -1;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int hs_cyc = 0;
    int busy_cnt = 0;
    logic [31:0] addr_log[$];
    logic [31:0] data_log[$];

    always #5 clk_i = ~clk_i;

    conv1d_obi_fetch dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .len_i        (len_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .obi_req_o    (obi_req_o),
        .obi_gnt_i    (obi_gnt_i),
        .obi_addr_o   (obi_addr_o),
        .obi_we_o     (obi_we_o),
        .obi_be_o     (obi_be_o),
        .obi_wdata_o  (obi_wdata_o),
        .obi_rvalid_i (obi_rvalid_i),
        .obi_rdata_i  (obi_rdata_i),
`ifdef CONV1D_FETCH_ERR_EN
        .obi_err_i    (obi_err_i),
        .err_o        (err_o),
`endif
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i)
    );

    // Zero-wait memory: grant follows req unless stalled, data one cycle later.
    assign obi_gnt_i = obi_req_o & gnt_en;

    always @(posedge clk_i) begin
        cyc          <= cyc + 1;
        obi_rvalid_i <= obi_req_o && obi_gnt_i;
        obi_rdata_i  <= obi_addr_o ^ 32'hDEAD_0000;
`ifdef CONV1D_FETCH_ERR_EN
        obi_err_i    <= obi_req_o && obi_gnt_i && ((addr_log.size() - 1) == err_abs);
`endif
    end

    always @(negedge clk_i) begin
        if (obi_req_o && obi_gnt_i) addr_log.push_back(obi_addr_o);
        if (valid_o && ready_i) begin
            data_log.push_back(data_o);
            hs_cyc = cyc;
        end
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy_o) busy_cnt++;
`ifdef CONV1D_FETCH_ERR_EN
        if (obi_rvalid_i && obi_err_i) rerr_cyc = cyc;
        if (err_o && !err_prev) err_rise_cyc = cyc;
        err_prev = err_o;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_xfer(input logic [31:0] base, input logic [15:0] len);
        @(posedge clk_i); #1;
        base_addr_i = base;
        len_i       = len;
        start_i     = 1'b1;
        @(posedge clk_i); #1;
        start_i     = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i); #1;
            if (done_cnt > d0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int a0, d0, dc0, bc0, s_cyc;
        bit ok;

        // Reset values
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_req", obi_req_o, 0);
        chk("rst_addr", obi_addr_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_we", obi_we_o, 0);
        chk("rst_be", obi_be_o, 4'hF);
        chk("rst_wdata", obi_wdata_o, 0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        // Zero-wait memory, len 8 from 0x1000
        a0 = addr_log.size(); d0 = data_log.size(); dc0 = done_cnt;
        start_xfer(32'h1000, 16'd8);
        s_cyc = cyc;
        wait_done(dc0, 40, ok);
        chk("t1_done_seen", ok, 1);
        chk("t1_grants", addr_log.size() - a0, 8);
        chk("t1_words", data_log.size() - d0, 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t1_addr%0d", i), addr_log[a0 + i], 32'h1000 + 4 * i);
            chk($sformatf("t1_data%0d", i), data_log[d0 + i], (32'h1000 + 4 * i) ^ 32'hDEAD_0000);
        end
        chk("t1_done_after_hs", done_cyc - hs_cyc, 1);
        chk("t1_total_le11", (done_cyc - s_cyc) <= 11, 1);
        chk("t1_busy_fall", busy_o, 0);
        @(negedge clk_i);
        chk("t1_done_one_cycle", done_o, 0);

        // Grant stalled three cycles on the first request
        a0 = addr_log.size(); dc0 = done_cnt;
        @(posedge clk_i); #1;
        gnt_en = 1'b0;
        start_xfer(32'h2000, 16'd2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            chk($sformatf("t2_req_hold%0d", k), obi_req_o, 1);
            chk($sformatf("t2_addr_hold%0d", k), obi_addr_o, 32'h2000);
        end
        @(posedge clk_i); #1;
        gnt_en = 1'b1;
        wait_done(dc0, 40, ok);
        chk("t2_done_seen", ok, 1);
        chk("t2_grants", addr_log.size() - a0, 2);
        chk("t2_addr0", addr_log[a0], 32'h2000);
        chk("t2_addr1", addr_log[a0 + 1], 32'h2004);

        // Stream back-pressure limits issue to the FIFO depth
        a0 = addr_log.size(); d0 = data_log.size(); dc0 = done_cnt;
        @(posedge clk_i); #1;
        ready_i = 1'b0;
        start_xfer(32'h3000, 16'd8);
        repeat (20) @(negedge clk_i);
        chk("t3_grants_capped", addr_log.size() - a0, 4);
        chk("t3_req_low", obi_req_o, 0);
        chk("t3_valid", valid_o, 1);
        chk("t3_head", data_o, 32'hDEAD_3000);
        chk("t3_busy", busy_o, 1);
        @(posedge clk_i); #1;
        ready_i = 1'b1;
        wait_done(dc0, 60, ok);
        chk("t3_done_seen", ok, 1);
        chk("t3_words", data_log.size() - d0, 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("t3_data%0d", i), data_log[d0 + i], (32'h3000 + 4 * i) ^ 32'hDEAD_0000);

        // Zero length
        a0 = addr_log.size(); dc0 = done_cnt; bc0 = busy_cnt;
        start_xfer(32'h0, 16'd0);
        @(negedge clk_i);
        chk("t4_len0_done", done_o, 1);
        chk("t4_len0_busy", busy_o, 0);
        @(negedge clk_i);
        chk("t4_len0_done_off", done_o, 0);
        chk("t4_len0_no_busy", busy_cnt - bc0, 0);
        chk("t4_len0_no_req", addr_log.size() - a0, 0);

        // Start while busy is ignored
        a0 = addr_log.size(); d0 = data_log.size(); dc0 = done_cnt;
        start_xfer(32'h4000, 16'd3);
        @(posedge clk_i); #1;
        base_addr_i = 32'h5000; len_i = 16'd5; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        wait_done(dc0, 40, ok);
        chk("t4_done_seen", ok, 1);
        repeat (5) @(negedge clk_i);
        chk("t4_grants", addr_log.size() - a0, 3);
        chk("t4_words", data_log.size() - d0, 3);
        chk("t4_last_addr", addr_log[a0 + 2], 32'h4008);
        chk("t4_one_done", done_cnt - dc0, 1);
        chk("t4_idle", busy_o, 0);

        // Address wrap past the top of the address space
        a0 = addr_log.size(); d0 = data_log.size(); dc0 = done_cnt;
        start_xfer(32'hFFFF_FFF8, 16'd4);
        wait_done(dc0, 40, ok);
        chk("t5_done_seen", ok, 1);
        chk("t5_addr0", addr_log[a0], 32'hFFFF_FFF8);
        chk("t5_addr1", addr_log[a0 + 1], 32'hFFFF_FFFC);
        chk("t5_addr2", addr_log[a0 + 2], 32'h0000_0000);
        chk("t5_addr3", addr_log[a0 + 3], 32'h0000_0004);
        chk("t5_data2", data_log[d0 + 2], 32'hDEAD_0000);

        // Reset in the middle of a transfer
        @(posedge clk_i); #1;
        ready_i = 1'b0;
        start_xfer(32'h6000, 16'd8);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        chk("t6_busy", busy_o, 0);
        chk("t6_done", done_o, 0);
        chk("t6_req", obi_req_o, 0);
        chk("t6_addr", obi_addr_o, 0);
        chk("t6_valid", valid_o, 0);
        chk("t6_data", data_o, 0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        ready_i = 1'b1;
        d0 = data_log.size(); dc0 = done_cnt;
        start_xfer(32'h7000, 16'd2);
        wait_done(dc0, 40, ok);
        chk("t6_after_done", ok, 1);
        chk("t6_after_words", data_log.size() - d0, 2);
        chk("t6_after_data1", data_log[d0 + 1], 32'hDEAD_7004);

`ifdef CONV1D_FETCH_ERR_EN
        // Error on word 2 of 4
        chk("t7_err_clear", err_o, 0);
        d0 = data_log.size(); dc0 = done_cnt;
        err_abs = addr_log.size() + 1;
        start_xfer(32'h8000, 16'd4);
        wait_done(dc0, 40, ok);
        chk("t7_done_seen", ok, 1);
        chk("t7_err_set", err_o, 1);
        chk("t7_err_next_cycle", err_rise_cyc - rerr_cyc, 1);
        chk("t7_words", data_log.size() - d0, 4);
        start_xfer(32'h0, 16'd0);
        @(negedge clk_i);
        chk("t7_err_cleared", err_o, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
